bp_uncached_bypass: RTL and testbench
=====================================

// Module: bp_uncached_bypass
// PURPOSE
//  Uncached-access engine downstream of the physical-memory-attribute check. A request whose
//  PMA lookup flags it uncached (local/CFG space or I/O-NoC space) bypasses the cache and comes here.
//  The block issues one single-beat memory command, waits for the response (bounded by a timeout),
//  and returns aligned, zero-extended load data or a store-done pulse. One transaction in flight.
// PARAMETERS
//  ptag_width_p         28   physical tag width; paddr = {ptag, page_offset}
//  page_offset_width_p  12   page offset width
//  dword_width_p        64   memory data width (8 byte lanes)
//  timeout_cycles_p     256  max cycles in WAIT before abort (>=2)
// PORTS
//  clk_i             in   1    clock; all state updates on rising edge
//  reset_n_i         in   1    asynchronous, active-low reset
//  req_v_i           in   1    request valid
//  req_uncached_i    in   1    PMA uncached flag for this request
//  req_ready_o       out  1    engine idle, can accept
//  req_ptag_i        in   ptag_width_p         physical tag
//  req_offset_i      in   page_offset_width_p  page offset
//  req_we_i          in   1    1=store, 0=load
//  req_size_i        in   2    0/1/2/3 = 1/2/4/8 bytes
//  req_data_i        in   dword_width_p        store data, right-justified
//  mem_cmd_v_o       out  1    command valid
//  mem_cmd_ready_i   in   1    memory accepts command
//  mem_cmd_addr_o    out  ptag_width_p+page_offset_width_p
//  mem_cmd_we_o      out  1
//  mem_cmd_size_o    out  2
//  mem_cmd_data_o    out  dword_width_p        store data replicated across lanes
//  mem_resp_v_i      in   1    response valid
//  mem_resp_data_i   in   dword_width_p        full dword, unaligned
//  mem_resp_yumi_o   out  1    response consumed this cycle
//  load_v_o          out  1    load data valid
//  load_data_o       out  dword_width_p        aligned, zero-extended load data
//  load_ready_i      in   1    consumer accepts load data
//  store_done_o      out  1    one-cycle pulse: store acknowledged
//  error_o           out  1    one-cycle pulse: misaligned or timed out
// BEHAVIOUR
//  - States: IDLE, SEND, WAIT, REPLY. Reset (reset_n_i=0, async) -> IDLE; all *_v_o, yumi,
//    store_done_o, error_o = 0; timeout counter = 0; data regs = 0. Reset mid-transaction abandons it.
//  - req_ready_o = (state==IDLE). Accept iff req_v_i & req_uncached_i & req_ready_o;
//    req_v_i with req_uncached_i=0 is ignored (cached path owns it).
//  - Alignment: offset[2:0] must be multiple of 2^size. Misaligned accept: stay IDLE, error_o=1
//    next cycle, no mem command.
//  - IDLE->SEND on aligned accept; addr/we/size/data latched. mem_cmd_v_o=1 in SEND, cycle after
//    accept; fields stable until mem_cmd_ready_i. Store data lane-replicated: size0 x8, size1 x4,
//    size2 x2, size3 x1.
//  - SEND->WAIT on mem_cmd_v_o & mem_cmd_ready_i; counter cleared.
//  - WAIT: mem_resp_yumi_o = mem_resp_v_i (combinational). On response: store -> store_done_o=1 next
//    cycle, go IDLE; load -> capture (resp >> 8*offset[2:0]) masked to 2^size bytes, go REPLY.
//  - WAIT timeout: counter++ each cycle without response; at count==timeout_cycles_p-1 with no
//    response -> IDLE, error_o=1 next cycle. Response on that same cycle wins (no error).
//  - REPLY: load_v_o=1, load_data_o stable; on load_ready_i -> IDLE. Next request accepted the
//    cycle after handshake.
//  - Stray mem_resp_v_i outside WAIT: yumi'd and dropped; no output effect.
//  - Latency (zero-wait mem): accept N, cmd N+1, resp N+2, load_v_o/store_done_o N+3.
// TESTING
//  1 Load size2 offset 0x004, ptag 0x0000001, resp 0x11223344_55667788 -> addr 0x1004, load_data 0x11223344.
//  2 Store size0 offset 0x003, data 0xAB -> mem_cmd_data 0xABABABAB_ABABABAB, store_done_o 1 cycle.
//  3 Misaligned size3 offset 0x004 -> error_o pulse, no mem_cmd_v_o, req_ready_o high next cycle.
//  4 No response for 256 WAIT cycles -> error_o pulse, IDLE; response on cycle 255 -> no error.
//  5 req_v_i=1, req_uncached_i=0 -> not accepted; mem_cmd_ready_i=0 10 cycles -> cmd fields held.
//  6 reset_n_i low during WAIT -> IDLE; late resp yumi'd, no load_v_o.

Source files
------------

// File: rtl/bp_uncached_bypass.sv
// Uncached-access engine: issues one single-beat memory command per request that the PMA check
// flags uncached. It returns aligned, zero-extended load data or a store-done pulse, and signals
// misalignment or a response timeout with a one-cycle error pulse.
module bp_uncached_bypass #(
    parameter int ptag_width_p        = 28,
    parameter int page_offset_width_p = 12,
    parameter int dword_width_p       = 64,
    parameter int timeout_cycles_p    = 256
) (
    input  logic                                          clk_i,
    input  logic                                          reset_n_i,
    input  logic                                          req_v_i,
    input  logic                                          req_uncached_i,
    output logic                                          req_ready_o,
    input  logic [ptag_width_p-1:0]                       req_ptag_i,
    input  logic [page_offset_width_p-1:0]                req_offset_i,
    input  logic                                          req_we_i,
    input  logic [1:0]                                    req_size_i,
    input  logic [dword_width_p-1:0]                      req_data_i,
    output logic                                          mem_cmd_v_o,
    input  logic                                          mem_cmd_ready_i,
    output logic [ptag_width_p+page_offset_width_p-1:0]   mem_cmd_addr_o,
    output logic                                          mem_cmd_we_o,
    output logic [1:0]                                    mem_cmd_size_o,
    output logic [dword_width_p-1:0]                      mem_cmd_data_o,
    input  logic                                          mem_resp_v_i,
    input  logic [dword_width_p-1:0]                      mem_resp_data_i,
    output logic                                          mem_resp_yumi_o,
    output logic                                          load_v_o,
    output logic [dword_width_p-1:0]                      load_data_o,
    input  logic                                          load_ready_i,
    output logic                                          store_done_o,
    output logic                                          error_o
);

    localparam int paddr_width_lp = ptag_width_p + page_offset_width_p;
    localparam int bytes_lp       = dword_width_p / 8;
    localparam int cnt_width_lp   = $clog2(timeout_cycles_p);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, REPLY} state_e;

    state_e                     state_r;
    logic [paddr_width_lp-1:0]  addr_r;
    logic                       we_r;
    logic [1:0]                 size_r;
    logic [dword_width_p-1:0]   data_r;
    logic [dword_width_p-1:0]   load_data_r;
    logic [cnt_width_lp-1:0]    cnt_r;
    logic                       store_done_r;
    logic                       error_r;

    function automatic logic is_aligned(input logic [2:0] off, input logic [1:0] sz);
        case (sz)
            2'd0:    is_aligned = 1'b1;
            2'd1:    is_aligned = (off[0] == 1'b0);
            2'd2:    is_aligned = (off[1:0] == 2'b00);
            default: is_aligned = (off == 3'b000);
        endcase
    endfunction

    // Copy the low 2^sz bytes of right-justified store data into every lane group.
    function automatic logic [dword_width_p-1:0] replicate_store(
        input logic [dword_width_p-1:0] d, input logic [1:0] sz);
        logic [dword_width_p-1:0] r;
        int                       w;
        r = '0;
        w = 1 << sz;
        for (int i = 0; i < bytes_lp; i++) begin
            r[8*i +: 8] = d[8*(i % w) +: 8];
        end
        return r;
    endfunction

    function automatic logic [dword_width_p-1:0] extract_load(
        input logic [dword_width_p-1:0] resp, input logic [2:0] off, input logic [1:0] sz);
        logic [dword_width_p-1:0] shifted;
        logic [dword_width_p-1:0] r;
        shifted = resp >> {off, 3'b000};
        r = '0;
        for (int i = 0; i < bytes_lp; i++) begin
            if (i < (1 << sz)) begin
                r[8*i +: 8] = shifted[8*i +: 8];
            end
        end
        return r;
    endfunction

    assign req_ready_o     = (state_r == IDLE);
    assign mem_cmd_v_o     = (state_r == SEND);
    assign mem_cmd_addr_o  = addr_r;
    assign mem_cmd_we_o    = we_r;
    assign mem_cmd_size_o  = size_r;
    assign mem_cmd_data_o  = data_r;
    // Responses are always consumed; outside WAIT they are simply discarded.
    assign mem_resp_yumi_o = mem_resp_v_i & reset_n_i;
    assign load_v_o        = (state_r == REPLY);
    assign load_data_o     = load_data_r;
    assign store_done_o    = store_done_r;
    assign error_o         = error_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r      <= IDLE;
            addr_r       <= '0;
            we_r         <= 1'b0;
            size_r       <= 2'd0;
            data_r       <= '0;
            load_data_r  <= '0;
            cnt_r        <= '0;
            store_done_r <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            store_done_r <= 1'b0;
            error_r      <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_v_i && req_uncached_i) begin
                        if (is_aligned(req_offset_i[2:0], req_size_i)) begin
                            addr_r  <= {req_ptag_i, req_offset_i};
                            we_r    <= req_we_i;
                            size_r  <= req_size_i;
                            data_r  <= replicate_store(req_data_i, req_size_i);
                            state_r <= SEND;
                        end else begin
                            error_r <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (mem_cmd_ready_i) begin
                        cnt_r   <= '0;
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    // A response arriving on the final timeout cycle takes priority over the abort.
                    if (mem_resp_v_i) begin
                        if (we_r) begin
                            store_done_r <= 1'b1;
                            state_r      <= IDLE;
                        end else begin
                            load_data_r <= extract_load(mem_resp_data_i, addr_r[2:0], size_r);
                            state_r     <= REPLY;
                        end
                    end else if (cnt_r == cnt_width_lp'(timeout_cycles_p - 1)) begin
                        error_r <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                REPLY: begin
                    if (load_ready_i) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_uncached_bypass.sv
// Directed bench for bp_uncached_bypass: loads, stores, misalignment, timeout,
// non-uncached requests, command back-pressure and mid-transaction reset.
module tb_bp_uncached_bypass;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_v, req_uncached, req_ready, req_we;
    logic [27:0] req_ptag;
    logic [11:0] req_offset;
    logic [1:0]  req_size;
    logic [63:0] req_data;
    logic        mem_cmd_v, mem_cmd_ready, mem_cmd_we;
    logic [39:0] mem_cmd_addr;
    logic [1:0]  mem_cmd_size;
    logic [63:0] mem_cmd_data;
    logic        mem_resp_v, mem_resp_yumi;
    logic [63:0] mem_resp_data;
    logic        load_v, load_ready, store_done, error;
    logic [63:0] load_data;

    int vectors = 0;
    int miscompares = 0;

    bp_uncached_bypass #(
        .ptag_width_p(28), .page_offset_width_p(12), .dword_width_p(64), .timeout_cycles_p(256)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .req_v_i(req_v), .req_uncached_i(req_uncached), .req_ready_o(req_ready),
        .req_ptag_i(req_ptag), .req_offset_i(req_offset), .req_we_i(req_we),
        .req_size_i(req_size), .req_data_i(req_data),
        .mem_cmd_v_o(mem_cmd_v), .mem_cmd_ready_i(mem_cmd_ready), .mem_cmd_addr_o(mem_cmd_addr),
        .mem_cmd_we_o(mem_cmd_we), .mem_cmd_size_o(mem_cmd_size), .mem_cmd_data_o(mem_cmd_data),
        .mem_resp_v_i(mem_resp_v), .mem_resp_data_i(mem_resp_data), .mem_resp_yumi_o(mem_resp_yumi),
        .load_v_o(load_v), .load_data_o(load_data), .load_ready_i(load_ready),
        .store_done_o(store_done), .error_o(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [27:0] ptag, input logic [11:0] off, input logic we,
                         input logic [1:0] sz, input logic [63:0] d);
        req_v = 1'b1; req_uncached = 1'b1;
        req_ptag = ptag; req_offset = off; req_we = we; req_size = sz; req_data = d;
        tick();
        req_v = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [27:0] ptag, input logic [11:0] off,
                           input logic [1:0] sz, input logic [63:0] resp,
                           input logic [63:0] exp_addr, input logic [63:0] exp_data);
        issue(ptag, off, 1'b0, sz, 64'h0);
        chk({tag, "_cmdv"}, 64'(mem_cmd_v), 64'd1);
        chk({tag, "_addr"}, 64'(mem_cmd_addr), exp_addr);
        chk({tag, "_size"}, 64'(mem_cmd_size), 64'(sz));
        chk({tag, "_busy"}, 64'(req_ready), 64'd0);
        mem_cmd_ready = 1'b1;
        tick();
        mem_cmd_ready = 1'b0;
        chk({tag, "_cmd_drop"}, 64'(mem_cmd_v), 64'd0);
        mem_resp_v = 1'b1; mem_resp_data = resp;
        #1;
        chk({tag, "_yumi"}, 64'(mem_resp_yumi), 64'd1);
        tick();
        mem_resp_v = 1'b0;
        chk({tag, "_ldv"}, 64'(load_v), 64'd1);
        chk({tag, "_data"}, load_data, exp_data);
        tick();
        chk({tag, "_hold"}, load_data, exp_data);
        load_ready = 1'b1;
        tick();
        load_ready = 1'b0;
        chk({tag, "_ldv_off"}, 64'(load_v), 64'd0);
        chk({tag, "_idle"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        req_v = 1'b0; req_uncached = 1'b0; req_ptag = '0; req_offset = '0;
        req_we = 1'b0; req_size = 2'd0; req_data = '0;
        mem_cmd_ready = 1'b0; mem_resp_v = 1'b0; mem_resp_data = '0; load_ready = 1'b0;
        tick(); tick();
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_cmdv", 64'(mem_cmd_v), 64'd0);
        chk("rst_ldv", 64'(load_v), 64'd0);
        chk("rst_done", 64'(store_done), 64'd0);
        chk("rst_err", 64'(error), 64'd0);
        chk("rst_yumi", 64'(mem_resp_yumi), 64'd0);
        reset_n = 1'b1;
        tick();

        // Loads of each size with alignment shifts
        do_load("ld_w", 28'h0000001, 12'h004, 2'd2, 64'h11223344_55667788, 64'h1004, 64'h11223344);
        do_load("ld_h", 28'h00ABCDE, 12'h036, 2'd1, 64'h11223344_55667788, 64'hABCDE036, 64'h1122);
        do_load("ld_b", 28'h0000003, 12'hFF1, 2'd0, 64'h11223344_55667788, 64'h3FF1, 64'h77);
        do_load("ld_d", 28'hFFFFFFF, 12'h008, 2'd3, 64'hDEADBEEF_CAFEF00D, 64'hFF_FFFF_F008,
                64'hDEADBEEF_CAFEF00D);

        // Byte store, lane replication and done pulse
        issue(28'h0000002, 12'h003, 1'b1, 2'd0, 64'hAB);
        chk("st_b_data", mem_cmd_data, 64'hABABABAB_ABABABAB);
        chk("st_b_we", 64'(mem_cmd_we), 64'd1);
        chk("st_b_addr", 64'(mem_cmd_addr), 64'h2003);
        mem_cmd_ready = 1'b1;
        tick();
        mem_cmd_ready = 1'b0;
        mem_resp_v = 1'b1;
        tick();
        mem_resp_v = 1'b0;
        chk("st_b_done", 64'(store_done), 64'd1);
        chk("st_b_noldv", 64'(load_v), 64'd0);
        chk("st_b_idle", 64'(req_ready), 64'd1);
        tick();
        chk("st_b_done_pulse", 64'(store_done), 64'd0);

        // Misaligned doubleword
        issue(28'h0000004, 12'h004, 1'b0, 2'd3, 64'h0);
        chk("mis_err", 64'(error), 64'd1);
        chk("mis_cmdv", 64'(mem_cmd_v), 64'd0);
        chk("mis_ready", 64'(req_ready), 64'd1);
        tick();
        chk("mis_err_pulse", 64'(error), 64'd0);
        chk("mis_cmdv2", 64'(mem_cmd_v), 64'd0);

        // Timeout after 256 WAIT cycles
        issue(28'h0000005, 12'h000, 1'b0, 2'd3, 64'h0);
        mem_cmd_ready = 1'b1;
        tick();
        mem_cmd_ready = 1'b0;
        for (int i = 0; i < 255; i++) tick();
        chk("to_still_wait", 64'(req_ready), 64'd0);
        chk("to_no_err_early", 64'(error), 64'd0);
        tick();
        chk("to_err", 64'(error), 64'd1);
        chk("to_idle", 64'(req_ready), 64'd1);
        tick();
        chk("to_err_pulse", 64'(error), 64'd0);

        // Response on the last WAIT cycle beats the timeout
        issue(28'h0000006, 12'h000, 1'b0, 2'd3, 64'h0);
        mem_cmd_ready = 1'b1;
        tick();
        mem_cmd_ready = 1'b0;
        for (int i = 0; i < 255; i++) tick();
        mem_resp_v = 1'b1; mem_resp_data = 64'h0123456789ABCDEF;
        tick();
        mem_resp_v = 1'b0;
        chk("late_no_err", 64'(error), 64'd0);
        chk("late_ldv", 64'(load_v), 64'd1);
        chk("late_data", load_data, 64'h0123456789ABCDEF);
        load_ready = 1'b1;
        tick();
        load_ready = 1'b0;

        // Cached request ignored
        req_v = 1'b1; req_uncached = 1'b0; req_ptag = 28'h7; req_offset = 12'h0;
        req_we = 1'b0; req_size = 2'd3;
        tick(); tick();
        req_v = 1'b0;
        chk("cached_cmdv", 64'(mem_cmd_v), 64'd0);
        chk("cached_ready", 64'(req_ready), 64'd1);
        chk("cached_err", 64'(error), 64'd0);

        // Command back-pressure: fields held while inputs change
        issue(28'h0000008, 12'h002, 1'b1, 2'd1, 64'hDEAD0000_00001234);
        req_ptag = 28'hFFFFFFF; req_offset = 12'hFFF; req_we = 1'b0;
        req_size = 2'd3; req_data = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            chk("bp_cmdv", 64'(mem_cmd_v), 64'd1);
            chk("bp_addr", 64'(mem_cmd_addr), 64'h8002);
            chk("bp_data", mem_cmd_data, 64'h12341234_12341234);
            tick();
        end
        chk("bp_we", 64'(mem_cmd_we), 64'd1);
        chk("bp_size", 64'(mem_cmd_size), 64'd1);
        mem_cmd_ready = 1'b1;
        tick();
        mem_cmd_ready = 1'b0;
        mem_resp_v = 1'b1;
        tick();
        mem_resp_v = 1'b0;
        chk("bp_done", 64'(store_done), 64'd1);

        // Reset during WAIT, then a stray response
        issue(28'h0000009, 12'h000, 1'b0, 2'd3, 64'h0);
        mem_cmd_ready = 1'b1;
        tick();
        mem_cmd_ready = 1'b0;
        tick(); tick();
        chk("rw_wait", 64'(req_ready), 64'd0);
        reset_n = 1'b0;
        #1;
        chk("rw_rst_idle", 64'(req_ready), 64'd1);
        chk("rw_rst_cmdv", 64'(mem_cmd_v), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        mem_resp_v = 1'b1; mem_resp_data = 64'hAAAA_BBBB_CCCC_DDDD;
        #1;
        chk("rw_stray_yumi", 64'(mem_resp_yumi), 64'd1);
        tick();
        mem_resp_v = 1'b0;
        chk("rw_no_ldv", 64'(load_v), 64'd0);
        chk("rw_no_done", 64'(store_done), 64'd0);
        chk("rw_no_err", 64'(error), 64'd0);
        chk("rw_ready", 64'(req_ready), 64'd1);

        // Engine still healthy afterwards
        do_load("post", 28'h000000A, 12'h004, 2'd2, 64'h11223344_55667788, 64'hA004, 64'h11223344);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
